// File: rtl/ctrl_word_pipe_pkg.sv
// Shared RV32I decode types: opcodes, ALU/compare encodings, mux selects,
// the base control word and the extended control word carried down the pipe.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    f3_add  = 3'b000,
    f3_sll  = 3'b001,
    f3_slt  = 3'b010,
    f3_sltu = 3'b011,
    f3_xor  = 3'b100,
    f3_sr   = 3'b101,
    f3_or   = 3'b110,
    f3_and  = 3'b111
  } arith_funct3_t;

  // ALU operand A select
  localparam logic       ALUMUX1_RS1 = 1'b0;
  localparam logic       ALUMUX1_PC  = 1'b1;
  // ALU operand B select
  localparam logic [2:0] ALUMUX2_I   = 3'd0;
  localparam logic [2:0] ALUMUX2_U   = 3'd1;
  localparam logic [2:0] ALUMUX2_B   = 3'd2;
  localparam logic [2:0] ALUMUX2_S   = 3'd3;
  localparam logic [2:0] ALUMUX2_J   = 3'd4;
  localparam logic [2:0] ALUMUX2_RS2 = 3'd5;
  // comparator operand B select
  localparam logic       CMPMUX_RS2  = 1'b0;
  localparam logic       CMPMUX_IMM  = 1'b1;
  // register-file write-data select
  localparam logic [3:0] RF_ALU      = 4'd0;
  localparam logic [3:0] RF_BR_EN    = 4'd1;
  localparam logic [3:0] RF_U_IMM    = 4'd2;
  localparam logic [3:0] RF_LW       = 4'd3;
  localparam logic [3:0] RF_PC4      = 4'd4;
  localparam logic [3:0] RF_LB       = 4'd5;
  localparam logic [3:0] RF_LBU      = 4'd6;
  localparam logic [3:0] RF_LH       = 4'd7;
  localparam logic [3:0] RF_LHU      = 4'd8;

  localparam logic [6:0] MEXT_FUNCT7 = 7'b0000001;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] aluop;
    logic [2:0] cmpop;
    logic       alumux1_sel;
    logic [2:0] alumux2_sel;
    logic       cmpmux_sel;
    logic [3:0] regfilemux_sel;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
    logic       is_branch;
    logic       is_jump;
  } rv32i_control_word;

  typedef struct packed {
    rv32i_control_word ctrl;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              mext;
    logic [2:0]        mext_op;
    logic              illegal;
  } ctrl_ext_t;

  // True when an instruction with this opcode reads register rs1
  function automatic logic reads_rs1(input logic [6:0] opcode);
    case (opcode)
      op_jalr, op_br, op_load, op_store, op_imm, op_reg: reads_rs1 = 1'b1;
      default:                                            reads_rs1 = 1'b0;
    endcase
  endfunction

  // True when an instruction with this opcode reads register rs2
  function automatic logic reads_rs2(input logic [6:0] opcode);
    case (opcode)
      op_reg, op_store, op_br: reads_rs2 = 1'b1;
      default:                 reads_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_word_pipe_decode_core.sv
// Combinational RV32I (+ optional RV32M) decoder producing one extended
// control word per instruction.
module ctrl_decode_core
  import rv32i_types::*;
#(
  parameter bit MEXT_EN = 1'b0
) (
  input  logic [31:0] instr,
  output ctrl_ext_t   word
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Opcode-driven field decode; illegal encodings collapse to an all-zero word flagged illegal
  always_comb begin
    word                  = '0;
    is_illegal            = 1'b0;
    word.rd               = instr[11:7];
    word.rs1              = instr[19:15];
    word.rs2              = instr[24:20];
    word.ctrl.opcode      = opcode;
    word.ctrl.funct3      = funct3;
    word.ctrl.aluop       = alu_add;
    word.ctrl.alumux1_sel = ALUMUX1_RS1;
    word.ctrl.alumux2_sel = ALUMUX2_I;

    case (opcode)
      op_lui: begin
        word.ctrl.load_regfile   = 1'b1;
        word.ctrl.regfilemux_sel = RF_U_IMM;
      end
      op_auipc: begin
        word.ctrl.alumux1_sel  = ALUMUX1_PC;
        word.ctrl.alumux2_sel  = ALUMUX2_U;
        word.ctrl.load_regfile = 1'b1;
      end
      op_jal: begin
        word.ctrl.alumux1_sel    = ALUMUX1_PC;
        word.ctrl.alumux2_sel    = ALUMUX2_J;
        word.ctrl.regfilemux_sel = RF_PC4;
        word.ctrl.load_regfile   = 1'b1;
        word.ctrl.is_jump        = 1'b1;
      end
      op_jalr: begin
        word.ctrl.regfilemux_sel = RF_PC4;
        word.ctrl.load_regfile   = 1'b1;
        word.ctrl.is_jump        = 1'b1;
      end
      op_br: begin
        word.ctrl.alumux1_sel = ALUMUX1_PC;
        word.ctrl.alumux2_sel = ALUMUX2_B;
        word.ctrl.cmpop       = funct3;
        word.ctrl.cmpmux_sel  = CMPMUX_RS2;
        word.ctrl.is_branch   = 1'b1;
      end
      op_load: begin
        word.ctrl.mem_read     = 1'b1;
        word.ctrl.load_regfile = 1'b1;
        case (funct3)
          lb:      word.ctrl.regfilemux_sel = RF_LB;
          lh:      word.ctrl.regfilemux_sel = RF_LH;
          lw:      word.ctrl.regfilemux_sel = RF_LW;
          lbu:     word.ctrl.regfilemux_sel = RF_LBU;
          lhu:     word.ctrl.regfilemux_sel = RF_LHU;
          default: is_illegal = 1'b1;
        endcase
      end
      op_store: begin
        word.ctrl.alumux2_sel = ALUMUX2_S;
        word.ctrl.mem_write   = 1'b1;
        case (funct3)
          sb, sh, sw: word.ctrl.mem_write = 1'b1;
          default:    is_illegal = 1'b1;
        endcase
      end
      op_imm: begin
        word.ctrl.load_regfile = 1'b1;
        case (funct3)
          f3_slt: begin
            word.ctrl.cmpop          = blt;
            word.ctrl.cmpmux_sel     = CMPMUX_IMM;
            word.ctrl.regfilemux_sel = RF_BR_EN;
          end
          f3_sltu: begin
            word.ctrl.cmpop          = bltu;
            word.ctrl.cmpmux_sel     = CMPMUX_IMM;
            word.ctrl.regfilemux_sel = RF_BR_EN;
          end
          f3_sr:   word.ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
          default: word.ctrl.aluop = funct3;
        endcase
      end
      op_reg: begin
        word.ctrl.alumux2_sel = ALUMUX2_RS2;
        if (funct7 == MEXT_FUNCT7) begin
          if (MEXT_EN) begin
            word.mext              = 1'b1;
            word.mext_op           = funct3;
            word.ctrl.load_regfile = 1'b1;
          end else begin
            is_illegal = 1'b1;
          end
        end else begin
          word.ctrl.load_regfile = 1'b1;
          case (funct3)
            f3_add:  word.ctrl.aluop = funct7[5] ? alu_sub : alu_add;
            f3_sr:   word.ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
            f3_slt: begin
              word.ctrl.cmpop          = blt;
              word.ctrl.cmpmux_sel     = CMPMUX_RS2;
              word.ctrl.regfilemux_sel = RF_BR_EN;
            end
            f3_sltu: begin
              word.ctrl.cmpop          = bltu;
              word.ctrl.cmpmux_sel     = CMPMUX_RS2;
              word.ctrl.regfilemux_sel = RF_BR_EN;
            end
            default: word.ctrl.aluop = funct3;
          endcase
        end
      end
      default: is_illegal = 1'b1;
    endcase

    if (is_illegal) begin
      word         = '0;
      word.illegal = 1'b1;
    end

    if (word.rd == 5'd0) begin
      word.ctrl.load_regfile = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_word_pipe.sv
// Registered control-word pipeline: decode into stage 0, then carry the word
// down NUM_STAGES control registers with load-use bubbles, stall and flush.
module ctrl_word_pipe
  import rv32i_types::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter bit MEXT_EN     = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [31:0]           in_pc,
  input  logic                  stall_ext,
  input  logic                  flush,
  output logic [NUM_STAGES-1:0] stage_valid,
  output ctrl_ext_t             stage_ctrl [NUM_STAGES],
  output logic [31:0]           stage_pc   [NUM_STAGES],
  output logic                  hazard_stall,
  output logic [CNT_W-1:0]      bubble_cnt
);

  ctrl_ext_t        dec_word;
  logic             load_use_raw;
  logic             load_use;
  logic             accept;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  ctrl_decode_core #(
    .MEXT_EN (MEXT_EN)
  ) u_decode (
    .instr (in_instr),
    .word  (dec_word)
  );

  assign in_opcode = in_instr[6:0];
  assign in_rs1    = in_instr[19:15];
  assign in_rs2    = in_instr[24:20];

  // Load-use detection against stage 0 and the resulting handshake; flush overrides the bubble
  always_comb begin
    load_use_raw = stage_valid[0]
                && (stage_ctrl[0].ctrl.opcode == op_load)
                && (stage_ctrl[0].rd != 5'd0)
                && in_valid
                && ((reads_rs1(in_opcode) && (in_rs1 == stage_ctrl[0].rd))
                 || (reads_rs2(in_opcode) && (in_rs2 == stage_ctrl[0].rd)));
    load_use     = load_use_raw && !flush;
    in_ready     = rst && !stall_ext && !load_use;
    hazard_stall = rst && !stall_ext && load_use;
    accept       = in_valid && in_ready;
  end

  // Saturating count of inserted load-use bubbles
  always_comb begin
    cnt_d = cnt_q;
    if (hazard_stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Bubble counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    localparam bit FLUSHABLE = (i < FLUSH_DEPTH);

    logic        valid_q;
    logic        valid_d;
    ctrl_ext_t   ctrl_q;
    ctrl_ext_t   ctrl_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        prev_valid;
    ctrl_ext_t   prev_ctrl;
    logic [31:0] prev_pc;

    if (i == 0) begin : g_head
      assign prev_valid = accept;
      assign prev_ctrl  = accept ? dec_word : '0;
      assign prev_pc    = accept ? in_pc : '0;
    end else begin : g_body
      assign prev_valid = stage_valid[i-1];
      assign prev_ctrl  = stage_ctrl[i-1];
      assign prev_pc    = stage_pc[i-1];
    end

    // Advance from the previous stage unless stalled; young stages are cleared on flush
    always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      pc_d    = pc_q;
      if (!stall_ext) begin
        valid_d = prev_valid;
        ctrl_d  = prev_ctrl;
        pc_d    = prev_pc;
      end
      if (flush && FLUSHABLE) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        pc_d    = '0;
      end
    end

    // Stage control register
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        pc_q    <= '0;
      end else begin
        valid_q <= valid_d;
        ctrl_q  <= ctrl_d;
        pc_q    <= pc_d;
      end
    end

    assign stage_valid[i] = valid_q;
    assign stage_ctrl[i]  = ctrl_q;
    assign stage_pc[i]    = pc_q;
  end

endmodule
